prirv32_branch_resolve: RTL and testbench



---
 rtl/prirv32_pkg.sv | 30 +++
 rtl/prirv32_pred_fifo.sv | 44 ++++
 rtl/prirv32_branch_resolve.sv | 141 ++++++++++++++
 tb/tb_prirv32_branch_resolve.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prirv32_pkg.sv
// Shared definitions for the branch-resolve slice:
// counter encoding, FSM states, counter update.
package prirv32_pkg;

    localparam logic [1:0] STRONG_TOKEN   = 2'b00;
    localparam logic [1:0] WEAK_TOKEN     = 2'b01;
    localparam logic [1:0] WEAK_NOTOKEN   = 2'b10;
    localparam logic [1:0] STRONG_NOTOKEN = 2'b11;

    typedef enum logic {
        TRACK    = 1'b0,
        REDIRECT = 1'b1
    } bru_state_e;

    // Taken moves toward STRONG_TOKEN, not-taken toward STRONG_NOTOKEN.
    function automatic logic [1:0] sat_update(
        input logic [1:0] cur,
        input logic       taken
    );
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            if (cur != STRONG_TOKEN) nxt = cur - 2'd1;
        end else begin
            if (cur != STRONG_NOTOKEN) nxt = cur + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/prirv32_pred_fifo.sv
// Synchronous FIFO of outstanding predictions.
// Pointers carry an extra MSB to tell full from empty.
module prirv32_pred_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Clear drops everything, including a push in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/prirv32_branch_resolve.sv
// Branch resolve: prediction queue, BHT training, redirect on mispredict.
// Define PRIRV32_BRU_STATS_EN to add resolve/mispredict counters.
module prirv32_branch_resolve
    import prirv32_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pred_valid_i,
    output logic            pred_ready_o,
    input  logic [XLEN-1:0] pred_pc_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] pred_target_i,
    input  logic            res_valid_i,
    input  logic            res_taken_i,
    input  logic [XLEN-1:0] res_target_i,
    output logic            redirect_valid_o,
    input  logic            redirect_ready_i,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o,
    output logic            spurious_o,
`ifdef PRIRV32_BRU_STATS_EN
    output logic [31:0]     stat_resolved_o,
    output logic [31:0]     stat_mispredict_o,
`endif
    input  logic [XLEN-1:0] bht_rd_pc_i,
    output logic [1:0]      bht_rd_state_o,
    output logic            bht_rd_taken_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int EW    = 2 * XLEN + 1;

    bru_state_e       state;
    logic [1:0]       bht [BHT_ENTRIES];
    logic             full;
    logic             empty;
    logic [EW-1:0]    head;
    logic [XLEN-1:0]  head_pc;
    logic             head_taken;
    logic [XLEN-1:0]  head_target;
    logic             push;
    logic             res_fire;
    logic             res_spur;
    logic             mispredict;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             unused_bits;

    assign head_pc     = head[EW-1 -: XLEN];
    assign head_taken  = head[XLEN];
    assign head_target = head[XLEN-1:0];

    assign pred_ready_o = !full && (state == TRACK);
    assign push         = pred_valid_i && pred_ready_o;
    assign res_fire     = res_valid_i && (state == TRACK) && !empty;
    assign res_spur     = res_valid_i && (state == TRACK) && empty;
    assign mispredict   = res_fire &&
                          ((res_taken_i != head_taken) ||
                           (res_taken_i && (res_target_i != head_target)));

    assign rd_idx = bht_rd_pc_i[IDX_W+1:2];
    assign wr_idx = head_pc[IDX_W+1:2];

    assign bht_rd_state_o = bht[rd_idx];
    assign bht_rd_taken_o = (bht_rd_state_o == STRONG_TOKEN) ||
                            (bht_rd_state_o == WEAK_TOKEN);

    assign unused_bits = ^{bht_rd_pc_i[XLEN-1:IDX_W+2], bht_rd_pc_i[1:0],
                           head_pc[1:0]};

    prirv32_pred_fifo #(
        .WIDTH(EW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk_i),
        .rst  (rst_i),
        .push (push),
        .pop  (res_fire),
        .clear(mispredict),
        .din  ({pred_pc_i, pred_taken_i, pred_target_i}),
        .full (full),
        .empty(empty),
        .head (head)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= STRONG_TOKEN;
        end else if (res_fire) begin
            bht[wr_idx] <= sat_update(bht[wr_idx], res_taken_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= TRACK;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            flush_o          <= 1'b0;
            spurious_o       <= 1'b0;
        end else begin
            flush_o    <= 1'b0;
            spurious_o <= res_spur;
            unique case (state)
                TRACK: begin
                    if (mispredict) begin
                        redirect_valid_o <= 1'b1;
                        redirect_pc_o    <= res_taken_i ? res_target_i
                                                        : head_pc + XLEN'(4);
                        flush_o          <= 1'b1;
                        state            <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready_i) begin
                        redirect_valid_o <= 1'b0;
                        state            <= TRACK;
                    end
                end
                default: state <= TRACK;
            endcase
        end
    end

`ifdef PRIRV32_BRU_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_resolved_o   <= '0;
            stat_mispredict_o <= '0;
        end else begin
            if (res_fire)   stat_resolved_o   <= stat_resolved_o + 32'd1;
            if (mispredict) stat_mispredict_o <= stat_mispredict_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_prirv32_branch_resolve.sv
// Directed-vector bench for prirv32_branch_resolve.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_prirv32_branch_resolve;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pred_valid_i;
    logic        pred_ready_o;
    logic [31:0] pred_pc_i;
    logic        pred_taken_i;
    logic [31:0] pred_target_i;
    logic        res_valid_i;
    logic        res_taken_i;
    logic [31:0] res_target_i;
    logic        redirect_valid_o;
    logic        redirect_ready_i;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic        spurious_o;
    logic [31:0] bht_rd_pc_i;
    logic [1:0]  bht_rd_state_o;
    logic        bht_rd_taken_o;
`ifdef PRIRV32_BRU_STATS_EN
    logic [31:0] stat_resolved_o;
    logic [31:0] stat_mispredict_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    prirv32_branch_resolve dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .pred_valid_i     (pred_valid_i),
        .pred_ready_o     (pred_ready_o),
        .pred_pc_i        (pred_pc_i),
        .pred_taken_i     (pred_taken_i),
        .pred_target_i    (pred_target_i),
        .res_valid_i      (res_valid_i),
        .res_taken_i      (res_taken_i),
        .res_target_i     (res_target_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_ready_i (redirect_ready_i),
        .redirect_pc_o    (redirect_pc_o),
        .flush_o          (flush_o),
        .spurious_o       (spurious_o),
`ifdef PRIRV32_BRU_STATS_EN
        .stat_resolved_o  (stat_resolved_o),
        .stat_mispredict_o(stat_mispredict_o),
`endif
        .bht_rd_pc_i      (bht_rd_pc_i),
        .bht_rd_state_o   (bht_rd_state_o),
        .bht_rd_taken_o   (bht_rd_taken_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt);
        pred_valid_i  = 1'b1;
        pred_pc_i     = pc;
        pred_taken_i  = tk;
        pred_target_i = tgt;
        tick();
        pred_valid_i  = 1'b0;
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tgt);
        res_valid_i  = 1'b1;
        res_taken_i  = tk;
        res_target_i = tgt;
        tick();
        res_valid_i  = 1'b0;
    endtask

    task automatic bht_at(input logic [31:0] pc);
        bht_rd_pc_i = pc;
        #1;
    endtask

    logic [1:0] sat_exp [4];
    logic       tk_exp  [4];

    initial begin
        rst_i = 1'b0; pred_valid_i = 1'b0; pred_pc_i = '0;
        pred_taken_i = 1'b0; pred_target_i = '0;
        res_valid_i = 1'b0; res_taken_i = 1'b0; res_target_i = '0;
        redirect_ready_i = 1'b0; bht_rd_pc_i = '0;
        sat_exp[0] = 2'b01; sat_exp[1] = 2'b10;
        sat_exp[2] = 2'b11; sat_exp[3] = 2'b11;
        tk_exp[0] = 1'b1; tk_exp[1] = 1'b0;
        tk_exp[2] = 1'b0; tk_exp[3] = 1'b0;

        // reset state
        do_reset();
        bht_at(32'h40);
        chk("rst_bht_state", 32'(bht_rd_state_o), 32'd0);
        chk("rst_bht_taken", 32'(bht_rd_taken_o), 32'd1);
        chk("rst_redir_valid", 32'(redirect_valid_o), 32'd0);
        chk("rst_redir_pc", redirect_pc_o, 32'd0);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_spurious", 32'(spurious_o), 32'd0);
        chk("rst_ready", 32'(pred_ready_o), 32'd1);

        // correct taken prediction, then resolve on empty queue
        push(32'h100, 1'b1, 32'h80);
        resolve(1'b1, 32'h80);
        chk("ok_redir_valid", 32'(redirect_valid_o), 32'd0);
        chk("ok_flush", 32'(flush_o), 32'd0);
        bht_at(32'h100);
        chk("ok_bht_idx0", 32'(bht_rd_state_o), 32'd0);
        resolve(1'b1, 32'h0);
        chk("spur_pulse", 32'(spurious_o), 32'd1);
        chk("spur_bht", 32'(bht_rd_state_o), 32'd0);
        tick();
        chk("spur_one_cycle", 32'(spurious_o), 32'd0);

        // direction mispredict -> redirect to pc+4
        push(32'h100, 1'b1, 32'h80);
        resolve(1'b0, 32'h0);
        chk("mp_redir_valid", 32'(redirect_valid_o), 32'd1);
        chk("mp_redir_pc", redirect_pc_o, 32'h104);
        chk("mp_flush", 32'(flush_o), 32'd1);
        chk("mp_bht", 32'(bht_rd_state_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", 32'(redirect_valid_o), 32'd1);
            chk("hold_pc", redirect_pc_o, 32'h104);
            chk("hold_flush", 32'(flush_o), 32'd0);
            chk("hold_ready", 32'(pred_ready_o), 32'd0);
        end
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;
        chk("hs_valid", 32'(redirect_valid_o), 32'd0);
        chk("hs_ready", 32'(pred_ready_o), 32'd1);

        // saturation toward STRONG_NOTOKEN
        do_reset();
        bht_at(32'h100);
        for (int i = 0; i < 4; i++) begin
            push(32'h100, 1'b0, 32'h104);
            resolve(1'b0, 32'h0);
            chk("sat_state", 32'(bht_rd_state_o), 32'(sat_exp[i]));
            chk("sat_taken", 32'(bht_rd_taken_o), 32'(tk_exp[i]));
            chk("sat_no_redir", 32'(redirect_valid_o), 32'd0);
        end

        // fill queue; fifth push must be refused
        pred_valid_i  = 1'b1;
        pred_taken_i  = 1'b1;
        pred_target_i = 32'h300;
        for (int i = 0; i < 4; i++) begin
            pred_pc_i = 32'h200 + 32'(4 * i);
            tick();
        end
        chk("full_ready", 32'(pred_ready_o), 32'd0);
        pred_pc_i = 32'h210;
        tick();
        chk("full_ready2", 32'(pred_ready_o), 32'd0);
        res_valid_i  = 1'b1;
        res_taken_i  = 1'b1;
        res_target_i = 32'h300;
        tick();
        res_valid_i  = 1'b0;
        pred_valid_i = 1'b0;
        chk("pop_ready", 32'(pred_ready_o), 32'd1);
        chk("pop_no_redir", 32'(redirect_valid_o), 32'd0);
        bht_at(32'h200);
        chk("pop_bht", 32'(bht_rd_state_o), 32'd2);
        for (int i = 0; i < 3; i++) begin
            resolve(1'b1, 32'h300);
            chk("drain_no_redir", 32'(redirect_valid_o), 32'd0);
            chk("drain_no_spur", 32'(spurious_o), 32'd0);
        end
        resolve(1'b1, 32'h300);
        chk("fifth_dropped", 32'(spurious_o), 32'd1);
        chk("fifth_bht", 32'(bht_rd_state_o), 32'd2);

        // target mispredict, same-cycle push discarded
        push(32'h300, 1'b1, 32'h400);
        res_valid_i   = 1'b1;
        res_taken_i   = 1'b1;
        res_target_i  = 32'h500;
        pred_valid_i  = 1'b1;
        pred_pc_i     = 32'h600;
        pred_taken_i  = 1'b0;
        tick();
        res_valid_i  = 1'b0;
        pred_valid_i = 1'b0;
        chk("tgt_redir_valid", 32'(redirect_valid_o), 32'd1);
        chk("tgt_redir_pc", redirect_pc_o, 32'h500);
        chk("tgt_flush", 32'(flush_o), 32'd1);
        bht_at(32'h300);
        chk("tgt_bht", 32'(bht_rd_state_o), 32'd1);
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;
        resolve(1'b0, 32'h0);
        chk("clear_spur", 32'(spurious_o), 32'd1);
        chk("clear_no_redir", 32'(redirect_valid_o), 32'd0);

        // pc+4 wraps; reset during REDIRECT
        push(32'hFFFF_FFFC, 1'b1, 32'h10);
        resolve(1'b0, 32'h0);
        chk("wrap_valid", 32'(redirect_valid_o), 32'd1);
        chk("wrap_pc", redirect_pc_o, 32'h0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("midrst_valid", 32'(redirect_valid_o), 32'd0);
        chk("midrst_flush", 32'(flush_o), 32'd0);
        chk("midrst_ready", 32'(pred_ready_o), 32'd1);
        bht_at(32'h300);
        chk("midrst_bht", 32'(bht_rd_state_o), 32'd0);
        resolve(1'b1, 32'h0);
        chk("midrst_empty", 32'(spurious_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
